pc_branch_unit: RTL and testbench

PC_BRANCH_UNIT -- requirements
Module: PCBranchUnit

---
 rtl/pc_branch_unit.sv | 107 ++++++++++
 tb/tb_pc_branch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_unit
// Description : Program counter with branch/jump redirect and stall-held
//               pending redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchReq,
  input  logic        BranchTaken,
  input  logic [31:0] BranchBasePC,
  input  logic [31:0] ShiftedOffset,
  input  logic        JumpReq,
  input  logic [25:0] JumpIndex,
  input  logic [31:0] JumpBasePC,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] BranchTarget,
  output logic        Redirect,
  output logic        Pending
);

  localparam logic [31:0] c_pcStep    = 32'd4;
  localparam logic [31:0] c_upperMask = 32'hF000_0000;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] w_nextPc;
  logic [31:0] r_storedTarget;
  logic [31:0] w_nextTarget;
  logic        r_redirect;
  logic        w_nextRedirect;

  logic        w_haveReq;
  logic [31:0] w_jumpTarget;
  logic [31:0] w_reqTarget;

  assign PCPlus4      = r_pc + c_pcStep;
  assign BranchTarget = BranchBasePC + ShiftedOffset;

  // Masking keeps every JumpBasePC bit in the expression; only [31:28] survive.
  assign w_jumpTarget = (JumpBasePC & c_upperMask) | {4'b0000, JumpIndex, 2'b00};
  assign w_haveReq    = JumpReq | (BranchReq & BranchTaken);
  assign w_reqTarget  = JumpReq ? w_jumpTarget : BranchTarget;

  always_comb begin
    w_nextState    = r_state;
    w_nextPc       = r_pc;
    w_nextTarget   = r_storedTarget;
    w_nextRedirect = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!Stall) begin
          if (w_haveReq) begin
            w_nextPc       = w_reqTarget;
            w_nextRedirect = 1'b1;
          end else begin
            w_nextPc = PCPlus4;
          end
        end else if (w_haveReq) begin
          w_nextTarget = w_reqTarget;
          w_nextState  = S_HOLD;
        end
      end
      S_HOLD: begin
        // The older captured redirect wins; anything arriving now is dropped.
        if (!Stall) begin
          w_nextPc       = r_storedTarget;
          w_nextRedirect = 1'b1;
          w_nextState    = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_storedTarget <= 32'd0;
      r_redirect     <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_pc           <= w_nextPc;
      r_storedTarget <= w_nextTarget;
      r_redirect     <= w_nextRedirect;
    end
  end

  assign PC       = r_pc;
  assign Redirect = r_redirect;
  assign Pending  = (r_state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_branch_unit
// Description : Directed bench with a behavioural PC model and literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        Rst, Stall, BranchReq, BranchTaken, JumpReq;
  logic [31:0] BranchBasePC, ShiftedOffset, JumpBasePC;
  logic [25:0] JumpIndex;
  logic [31:0] PC, PCPlus4, BranchTarget;
  logic        Redirect, Pending;

  logic        rst2;
  logic [31:0] pc2, pcPlus4_2, branchTarget2;
  logic        redirect2, pending2;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  pc_branch_unit dut (
    .Clk(clk), .Rst(Rst), .Stall(Stall), .BranchReq(BranchReq),
    .BranchTaken(BranchTaken), .BranchBasePC(BranchBasePC),
    .ShiftedOffset(ShiftedOffset), .JumpReq(JumpReq), .JumpIndex(JumpIndex),
    .JumpBasePC(JumpBasePC), .PC(PC), .PCPlus4(PCPlus4),
    .BranchTarget(BranchTarget), .Redirect(Redirect), .Pending(Pending)
  );

  pc_branch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .Clk(clk), .Rst(rst2), .Stall(1'b0), .BranchReq(1'b0),
    .BranchTaken(1'b0), .BranchBasePC(32'd0), .ShiftedOffset(32'd0),
    .JumpReq(1'b0), .JumpIndex(26'd0), .JumpBasePC(32'd0), .PC(pc2),
    .PCPlus4(pcPlus4_2), .BranchTarget(branchTarget2),
    .Redirect(redirect2), .Pending(pending2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: PC, pending target and redirect pulse.
  logic [31:0] mPC, mTgt;
  logic        mRed, mHold, mValid;
  initial mValid = 1'b0;

  always @(posedge clk) begin : model
    logic [31:0] tgt;
    logic        req;
    if (Rst) begin
      mPC = 32'd0; mTgt = 32'd0; mRed = 1'b0; mHold = 1'b0; mValid = 1'b1;
    end else if (mValid) begin
      req = JumpReq || (BranchReq && BranchTaken);
      if (JumpReq) tgt = {JumpBasePC[31:28], JumpIndex, 2'b00};
      else         tgt = BranchBasePC + ShiftedOffset;
      if (mHold) begin
        if (Stall) mRed = 1'b0;
        else begin mPC = mTgt; mRed = 1'b1; mHold = 1'b0; end
      end else if (Stall) begin
        mRed = 1'b0;
        if (req) begin mHold = 1'b1; mTgt = tgt; end
      end else if (req) begin
        mPC = tgt; mRed = 1'b1;
      end else begin
        mPC = mPC + 32'd4; mRed = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      chk("model_pc", PC, mPC);
      chk("model_pcplus4", PCPlus4, mPC + 32'd4);
      chk("model_btarget", BranchTarget, BranchBasePC + ShiftedOffset);
      chk("model_redirect", {31'd0, Redirect}, {31'd0, mRed});
      chk("model_pending", {31'd0, Pending}, {31'd0, mHold});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearReq();
    BranchReq = 1'b0; BranchTaken = 1'b0; JumpReq = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; rst2 = 1'b1; Stall = 1'b0;
    BranchReq = 1'b0; BranchTaken = 1'b0; JumpReq = 1'b0;
    BranchBasePC = 32'd0; ShiftedOffset = 32'd0; JumpBasePC = 32'd0; JumpIndex = 26'd0;
    tick(); tick();
    chk("reset_pc", PC, 32'h0);
    chk("reset_redirect", {31'd0, Redirect}, 32'd0);
    chk("reset_pending", {31'd0, Pending}, 32'd0);
    chk("wrap_reset_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", pcPlus4_2, 32'h0);
    Rst = 1'b0; rst2 = 1'b0;

    // Free run from reset
    tick(); chk("run_pc1", PC, 32'h4); chk("run_red1", {31'd0, Redirect}, 32'd0);
    chk("wrap_pc_next", pc2, 32'h0);
    tick(); chk("run_pc2", PC, 32'h8);
    tick(); chk("run_pc3", PC, 32'hC); chk("run_red3", {31'd0, Redirect}, 32'd0);

    // Backward taken branch
    BranchBasePC = 32'h10; ShiftedOffset = 32'hFFFF_FFF8; BranchReq = 1'b1; BranchTaken = 1'b1;
    #1 chk("btarget_neg", BranchTarget, 32'h8);
    tick(); chk("br_pc", PC, 32'h8); chk("br_red", {31'd0, Redirect}, 32'd1);
    clearReq();
    tick(); chk("br_after_pc", PC, 32'hC); chk("br_after_red", {31'd0, Redirect}, 32'd0);

    // Not-taken branch is sequential
    BranchReq = 1'b1; BranchTaken = 1'b0;
    tick(); chk("nt_pc", PC, 32'h10); chk("nt_red", {31'd0, Redirect}, 32'd0);

    // Jump beats simultaneous taken branch
    JumpReq = 1'b1; JumpIndex = 26'h000_0040; JumpBasePC = 32'h4000_0000;
    BranchReq = 1'b1; BranchTaken = 1'b1;
    tick(); chk("jmp_pc", PC, 32'h4000_0100); chk("jmp_red", {31'd0, Redirect}, 32'd1);
    clearReq();
    tick(); chk("jmp_after_pc", PC, 32'h4000_0104);

    // Stalled branch, competing jump during stall and on release
    BranchBasePC = 32'h80; ShiftedOffset = 32'h80; BranchReq = 1'b1; BranchTaken = 1'b1;
    Stall = 1'b1;
    tick(); chk("hold_pc1", PC, 32'h4000_0104); chk("hold_pend1", {31'd0, Pending}, 32'd1);
    clearReq(); JumpReq = 1'b1; JumpIndex = 26'h3FF_FFFF; JumpBasePC = 32'h2000_0000;
    tick(); chk("hold_pc2", PC, 32'h4000_0104); chk("hold_pend2", {31'd0, Pending}, 32'd1);
    tick(); chk("hold_pc3", PC, 32'h4000_0104); chk("hold_pend3", {31'd0, Pending}, 32'd1);
    chk("hold_red3", {31'd0, Redirect}, 32'd0);
    Stall = 1'b0;
    tick(); chk("rel_pc", PC, 32'h100); chk("rel_red", {31'd0, Redirect}, 32'd1);
    chk("rel_pend", {31'd0, Pending}, 32'd0);
    clearReq();
    tick(); chk("rel_after_pc", PC, 32'h104); chk("rel_after_red", {31'd0, Redirect}, 32'd0);

    // Idle stall without request holds PC
    Stall = 1'b1;
    tick(); chk("idle_stall_pc", PC, 32'h104); chk("idle_stall_pend", {31'd0, Pending}, 32'd0);

    // Reset during HOLD discards stored target
    BranchBasePC = 32'h80; ShiftedOffset = 32'h80; BranchReq = 1'b1; BranchTaken = 1'b1;
    tick(); chk("prerst_pend", {31'd0, Pending}, 32'd1);
    clearReq(); Rst = 1'b1;
    tick(); chk("midrst_pc", PC, 32'h0); chk("midrst_pend", {31'd0, Pending}, 32'd0);
    chk("midrst_red", {31'd0, Redirect}, 32'd0);
    Rst = 1'b0; Stall = 1'b0;
    tick(); chk("postrst_pc", PC, 32'h4); chk("postrst_red", {31'd0, Redirect}, 32'd0);
    tick(); chk("postrst_pc2", PC, 32'h8);

    // Misaligned target, then back-to-back redirects
    BranchBasePC = 32'h101; ShiftedOffset = 32'h2; BranchReq = 1'b1; BranchTaken = 1'b1;
    tick(); chk("misal_pc", PC, 32'h103); chk("misal_red", {31'd0, Redirect}, 32'd1);
    BranchBasePC = 32'h200; ShiftedOffset = 32'h20;
    tick(); chk("b2b_pc", PC, 32'h220); chk("b2b_red", {31'd0, Redirect}, 32'd1);
    clearReq();
    tick(); chk("b2b_after_pc", PC, 32'h224); chk("b2b_after_red", {31'd0, Redirect}, 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
